// File: rtl/tx.sv
// UART transmitter: 8N1/8N2 frames, LSB first, idle-high line.
// A one-byte holding register lets the next byte queue so back-to-back frames have no gap.
module tx #(
  parameter int BAUD_DIV  = 16,
  parameter int STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_wr,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_tx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic        STOP_LAST = (STOP_BITS == 2);

  state_t      state, state_next;
  logic [7:0]  hold_data, hold_data_next;
  logic        hold_full, hold_full_next;
  logic [7:0]  shifter, shifter_next;
  logic [15:0] baud_cnt, baud_cnt_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic        stop_idx, stop_idx_next;
  logic        tx_next, done_next;
  logic        wr_acc, baud_wrap;

  always_comb begin
    state_next     = state;
    hold_data_next = hold_data;
    hold_full_next = hold_full;
    shifter_next   = shifter;
    bit_idx_next   = bit_idx;
    stop_idx_next  = stop_idx;
    tx_next        = o_tx;
    done_next      = 1'b0;
    wr_acc         = i_wr && o_ready;
    baud_wrap      = (baud_cnt == BAUD_LAST);
    baud_cnt_next  = baud_wrap ? 16'd0 : baud_cnt + 16'd1;

    if (wr_acc) begin
      hold_data_next = i_data;
      hold_full_next = 1'b1;
    end

    case (state)
      IDLE: begin
        tx_next       = 1'b1;
        baud_cnt_next = 16'd0;
        if (hold_full) begin
          shifter_next   = hold_data;
          hold_full_next = 1'b0;
          state_next     = START;
          tx_next        = 1'b0;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
          tx_next      = shifter[0];
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (bit_idx == 3'd7) begin
            state_next    = STOP;
            stop_idx_next = 1'b0;
            tx_next       = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shifter_next = {1'b0, shifter[7:1]};
            tx_next      = shifter[1];
          end
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (stop_idx == STOP_LAST) begin
            done_next = 1'b1;
            // A queued byte starts its start bit on this same edge: no idle gap.
            if (hold_full) begin
              shifter_next   = hold_data;
              hold_full_next = 1'b0;
              state_next     = START;
              tx_next        = 1'b0;
            end else begin
              state_next = IDLE;
              tx_next    = 1'b1;
            end
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      hold_data <= 8'd0;
      hold_full <= 1'b0;
      shifter   <= 8'd0;
      baud_cnt  <= 16'd0;
      bit_idx   <= 3'd0;
      stop_idx  <= 1'b0;
      o_tx      <= 1'b1;
      o_ready   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_next;
      hold_data <= hold_data_next;
      hold_full <= hold_full_next;
      shifter   <= shifter_next;
      baud_cnt  <= baud_cnt_next;
      bit_idx   <= bit_idx_next;
      stop_idx  <= stop_idx_next;
      o_tx      <= tx_next;
      o_ready   <= !hold_full_next;
      o_busy    <= (state_next != IDLE) || hold_full_next;
      o_done    <= done_next;
    end
  end

endmodule

// File: tb/tb_tx.sv
// Scoreboard bench for tx: accepted bytes are queued by the driver, a line decoder pops and
// compares every frame sample-by-sample; a second instance covers 2 stop bits at BAUD_DIV=16.
module tb_tx;
  localparam int BD  = 4;
  localparam int FR  = 10 * BD;
  localparam int BD2 = 16;
  localparam int FR2 = 11 * BD2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr, wr2;
  logic [7:0] data, data2;
  logic       ready, busy, done, txl;
  logic       ready2, busy2, done2, tx2;

  int n_chk = 0;
  int n_err = 0;
  int n_exp = 0;
  int frames_seen = 0;

  logic [7:0] exp_q[$];
  time        acc_q[$];

  always #5 clk = ~clk;

  tx #(.BAUD_DIV(BD), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_wr(wr),
    .o_ready(ready), .o_busy(busy), .o_done(done), .o_tx(txl)
  );

  tx #(.BAUD_DIV(BD2), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(data2), .i_wr(wr2),
    .o_ready(ready2), .o_busy(busy2), .o_done(done2), .o_tx(tx2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write one byte when the holding register is free; the byte is accepted on the next edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("send_ready_timeout", 32'd0, 32'd1);
    data = b;
    wr   = 1'b1;
    #1;
    exp_q.push_back(b);
    acc_q.push_back($time + 4);
    n_exp++;
    @(negedge clk);
    wr = 1'b0;
    chk("ready_low_after_write", 32'(ready), 32'd0);
    chk("busy_after_write", 32'(busy), 32'd1);
  endtask

  // Write attempt while the holding register is full: must be ignored.
  task automatic poke(input logic [7:0] b);
    data = b;
    wr   = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((frames_seen != n_exp || exp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("wait_idle_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Line monitor / receiver model.
  logic       prev_tx;
  logic       more, aborted;
  logic [9:0] pat;
  logic [7:0] exp_b;
  time        acc_t;
  int         bad;

  initial begin : monitor
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_tx = 1'b1;
      end else if (prev_tx && !txl) begin
        more = 1'b1;
        while (more) begin
          more = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
            exp_b = 8'h00;
            acc_t = 0;
          end else begin
            exp_b = exp_q.pop_front();
            acc_t = acc_q.pop_front();
          end
          pat = {1'b1, exp_b, 1'b0};
          bad = 0;
          aborted = 1'b0;
          for (int k = 0; k < FR; k++) begin
            if (k > 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (txl !== pat[k / BD]) bad++;
            if (k > 0 && done !== 1'b0) bad++;
          end
          if (!aborted) begin
            @(negedge clk);
            if (!rst) begin
              chk($sformatf("frame_%02h_bad_samples", exp_b), 32'(bad), 32'd0);
              chk("done_at_frame_end", 32'(done), 32'd1);
              chk("busy_at_frame_end", 32'(busy), 32'(exp_q.size() > 0));
              frames_seen++;
              if (exp_q.size() > 0 && acc_q[0] < $time - 5) begin
                chk("b2b_start_no_gap", 32'(txl), 32'd0);
                more = 1'b1;
              end else begin
                chk("line_high_after_stop", 32'(txl), 32'd1);
              end
            end
          end
        end
        prev_tx = rst ? 1'b1 : txl;
      end else begin
        prev_tx = txl;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [10:0] pat2;
  int          bad2;

  initial begin : driver
    rst = 1'b1; wr = 1'b0; data = 8'h00; wr2 = 1'b0; data2 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(txl), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx2", 32'(tx2), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 32'(ready), 32'd1);
    chk("ready2_after_release", 32'(ready2), 32'd1);

    // Two stop bits at BAUD_DIV=16: 0x81 -> 176-cycle frame.
    data2 = 8'h81;
    wr2   = 1'b1;
    @(negedge clk);
    wr2 = 1'b0;
    chk("ready2_low_after_write", 32'(ready2), 32'd0);
    @(negedge clk);
    pat2 = {2'b11, 8'h81, 1'b0};
    bad2 = 0;
    for (int k = 0; k < FR2; k++) begin
      if (tx2 !== pat2[k / BD2]) bad2++;
      if (done2 !== 1'b0) bad2++;
      if (busy2 !== 1'b1) bad2++;
      @(negedge clk);
    end
    chk("frame2_bad_samples", 32'(bad2), 32'd0);
    chk("done2_at_end", 32'(done2), 32'd1);
    chk("busy2_at_end", 32'(busy2), 32'd0);
    chk("tx2_high_at_end", 32'(tx2), 32'd1);
    @(negedge clk);
    chk("done2_one_cycle", 32'(done2), 32'd0);

    // Single byte: line idle at accept edge, start bit one edge later.
    send(8'hA5);
    chk("tx_idle_after_accept", 32'(txl), 32'd1);
    @(negedge clk);
    chk("tx_start_bit", 32'(txl), 32'd0);
    chk("ready_returns", 32'(ready), 32'd1);
    wait_idle();
    chk("busy_idle", 32'(busy), 32'd0);

    // Back-to-back.
    send(8'h00);
    send(8'hFF);
    wait_idle();

    // Write while full is dropped.
    send(8'h11);
    send(8'h22);
    poke(8'h33);
    wait_idle();

    // Reset during bit 3 of 0xC3.
    send(8'hC3);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    n_exp--;
    @(negedge clk);
    chk("midrst_tx", 32'(txl), 32'd1);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_release", 32'(ready), 32'd1);
    send(8'h5A);
    wait_idle();

    // Loopback-style sequence, then randomized traffic.
    send(8'h00); send(8'h55); send(8'hAA); send(8'hFF);
    wait_idle();
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) poke(8'($urandom_range(0, 255)));
    end
    wait_idle();

    chk("frames_seen", 32'(frames_seen), 32'(n_exp));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
